// File: rtl/tjmono_rx_core.sv
// tjmono_rx_core: readout receiver for one TJ-Monopix output.
// Watches the chip token and drives FREEZE/READ to pull one hit per READ
// pulse. It deserialises the 27-bit OUT stream and writes tagged 32-bit
// words to the downstream FIFO.
// Optional build macro: TJMONO_RX_GRAY_EN converts the LE/TE fields from
// Gray to binary before they are written. When the macro is undefined,
// LE/TE are written exactly as shifted in.
module tjmono_rx_core #(
   parameter logic [3:0] IDENTIFIER   = 4'h4,
   parameter int         DATA_BITS    = 27,
   parameter int         FREEZE_SETUP = 4
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        ENABLE,
   input  logic        TOKEN,
   input  logic        SER_DATA,
   output logic        FREEZE,
   output logic        READ,
   output logic [31:0] FIFO_DATA,
   output logic        FIFO_WRITE,
   input  logic        FIFO_FULL,
   output logic        BUSY,
   output logic [15:0] HIT_CNT
);

   typedef enum logic [2:0] {
      IDLE,
      FREEZE_WAIT,
      READ_PULSE,
      LOAD_WAIT,
      SHIFT,
      PUSH,
      UNFREEZE
   } state_t;

   localparam logic [3:0] SETUP_LOAD = 4'(FREEZE_SETUP);
   localparam logic [4:0] BIT_LOAD   = 5'(DATA_BITS - 1);

   state_t      state;
   state_t      state_next;
   logic        tok_meta;
   logic        tok_s;
   logic [3:0]  setup_cnt;
   logic [4:0]  bit_cnt;
   logic [25:0] sr;
   logic [26:0] hit_word;
   logic [26:0] hit_conv;

   // Gray-to-binary for one 6-bit timestamp field: MSB passes through and
   // each lower bit is XORed with the already-decoded bit above it.
   function automatic logic [5:0] gray2bin(input logic [5:0] g);
      logic [5:0] b;
      b[5] = g[5];
      for (int i = 4; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // The chip token is asynchronous to CLK, so it goes through two flops
   // before the FSM looks at it.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         tok_meta <= 1'b0;
         tok_s    <= 1'b0;
      end else begin
         tok_meta <= TOKEN;
         tok_s    <= tok_meta;
      end
   end

   // The final serial bit is taken straight from the pad. This lets the
   // FIFO word be registered on the same edge that leaves SHIFT, so it is
   // already stable in the first PUSH cycle.
   always_comb begin
      hit_word = {sr, SER_DATA};
      hit_conv = hit_word;
`ifdef TJMONO_RX_GRAY_EN
      hit_conv[26:21] = gray2bin(hit_word[26:21]);
      hit_conv[20:15] = gray2bin(hit_word[20:15]);
`endif
   end

   // Readout FSM state register.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. A word that has begun shifting always reaches PUSH.
   // Losing ENABLE only stops further READ pulses from being issued.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (ENABLE && tok_s) begin
               state_next = FREEZE_WAIT;
            end
         end
         FREEZE_WAIT: begin
            if (!ENABLE) begin
               state_next = UNFREEZE;
            end else if (setup_cnt == 4'd0) begin
               state_next = READ_PULSE;
            end
         end
         READ_PULSE: state_next = LOAD_WAIT;
         LOAD_WAIT:  state_next = SHIFT;
         SHIFT: begin
            if (bit_cnt == 5'd0) begin
               state_next = PUSH;
            end
         end
         PUSH: begin
            if (!FIFO_FULL) begin
               state_next = (tok_s && ENABLE) ? READ_PULSE : UNFREEZE;
            end
         end
         UNFREEZE:   state_next = IDLE;
         default:    state_next = IDLE;
      endcase
   end

   // Outputs are decoded from the state alone. The exception is the FIFO
   // strobe, which must also respect back-pressure in the same cycle.
   always_comb begin
      FREEZE     = (state != IDLE) && (state != UNFREEZE);
      READ       = (state == READ_PULSE);
      FIFO_WRITE = (state == PUSH) && !FIFO_FULL;
      BUSY       = (state != IDLE);
   end

   // Datapath: setup and bit counters, shift register, output word and
   // hit counter. FIFO_DATA only changes when a new word is completed.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         setup_cnt <= 4'd0;
         bit_cnt   <= 5'd0;
         sr        <= 26'd0;
         FIFO_DATA <= 32'd0;
         HIT_CNT   <= 16'd0;
      end else begin
         case (state)
            IDLE: begin
               setup_cnt <= SETUP_LOAD;
            end
            FREEZE_WAIT: begin
               if (setup_cnt != 4'd0) begin
                  setup_cnt <= setup_cnt - 4'd1;
               end
            end
            LOAD_WAIT: begin
               bit_cnt <= BIT_LOAD;
            end
            SHIFT: begin
               sr <= {sr[24:0], SER_DATA};
               if (bit_cnt != 5'd0) begin
                  bit_cnt <= bit_cnt - 5'd1;
               end else begin
                  FIFO_DATA <= {IDENTIFIER, 1'b0, hit_conv};
               end
            end
            default: begin
            end
         endcase
         if (FIFO_WRITE) begin
            HIT_CNT <= HIT_CNT + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_tjmono_rx_core.sv
// Testbench for tjmono_rx_core. A small chip model answers each READ pulse
// by serialising the next queued hit word. A monitor logs READ, write and
// FREEZE edge cycles. Directed scenarios then compare that log against
// hand-computed values.
module tb_tjmono_rx_core;

   localparam int SETUP = 4;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        ENABLE = 1'b0;
   logic        TOKEN = 1'b0;
   logic        SER_DATA = 1'b0;
   logic        FIFO_FULL = 1'b0;
   logic        FREEZE;
   logic        READ;
   logic [31:0] FIFO_DATA;
   logic        FIFO_WRITE;
   logic        BUSY;
   logic [15:0] HIT_CNT;

   int          cyc = 0;
   int          compared = 0;
   int          mismatched = 0;
   int          readCyc[$];
   int          wrCyc[$];
   logic [31:0] wrData[$];
   int          freezeRise[$];
   int          freezeFall[$];
   logic        freezePrev = 1'b0;
   logic [26:0] chipWords[$];

   tjmono_rx_core #(
      .IDENTIFIER(4'h4),
      .DATA_BITS(27),
      .FREEZE_SETUP(SETUP)
   ) dut (
      .CLK(CLK),
      .RESET(RESET),
      .ENABLE(ENABLE),
      .TOKEN(TOKEN),
      .SER_DATA(SER_DATA),
      .FREEZE(FREEZE),
      .READ(READ),
      .FIFO_DATA(FIFO_DATA),
      .FIFO_WRITE(FIFO_WRITE),
      .FIFO_FULL(FIFO_FULL),
      .BUSY(BUSY),
      .HIT_CNT(HIT_CNT)
   );

   // Free-running clock and cycle index
   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Monitor: samples 3 time units after each rising edge and logs events
   always begin
      @(posedge CLK);
      #3;
      if (READ) readCyc.push_back(cyc);
      if (FIFO_WRITE) begin
         wrCyc.push_back(cyc);
         wrData.push_back(FIFO_DATA);
      end
      if (FREEZE && !freezePrev) freezeRise.push_back(cyc);
      if (!FREEZE && freezePrev) freezeFall.push_back(cyc);
      freezePrev = FREEZE;
   end

   // Chip model: READ seen in cycle r puts bit 26 on OUT during r+2 and
   // bit 0 during r+28
   always begin : chipModel
      logic [26:0] w;
      @(posedge CLK);
      #2;
      if (READ) begin
         w = (chipWords.size() > 0) ? chipWords.pop_front() : 27'h0;
         @(posedge CLK);
         #2;
         for (int i = 26; i >= 0; i--) begin
            @(posedge CLK);
            #2;
            SER_DATA = w[i];
         end
      end
   end

   // Global time limit so the run can never hang
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic tok, input logic full);
      ENABLE    = en;
      TOKEN     = tok;
      FIFO_FULL = full;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic waitUntil(input int c);
      while (cyc < c) tick(1);
   endtask

   task automatic waitRead(input int target, input string tag);
      int i;
      i = 0;
      while (readCyc.size() < target && i < 300) begin
         tick(1);
         i++;
      end
      checkOutput({tag, "_read_seen"}, 32'(readCyc.size() >= target), 32'd1);
   endtask

   task automatic waitIdle(input string tag);
      int i;
      i = 0;
      while (BUSY && i < 300) begin
         tick(1);
         i++;
      end
      checkOutput({tag, "_idle"}, 32'(BUSY), 32'd0);
   endtask

   // Serves one hit with FIFO space and returns the READ cycle
   task automatic singleFrame(input logic [26:0] word, input string tag, output int r);
      int base;
      base = readCyc.size();
      chipWords.push_back(word);
      applyStimulus(1'b1, 1'b1, 1'b0);
      waitRead(base + 1, tag);
      TOKEN = 1'b0;
      r = readCyc[base];
      waitIdle(tag);
      tick(2);
   endtask

   initial begin
      int t, r, e, rBase, wBase, fBase, ffBase;
      logic [31:0] heldData;

      // Reset values
      applyStimulus(1'b0, 1'b0, 1'b0);
      RESET = 1'b1;
      tick(3);
      checkOutput("rst_freeze", 32'(FREEZE), 32'd0);
      checkOutput("rst_read", 32'(READ), 32'd0);
      checkOutput("rst_write", 32'(FIFO_WRITE), 32'd0);
      checkOutput("rst_data", FIFO_DATA, 32'h0);
      checkOutput("rst_busy", 32'(BUSY), 32'd0);
      checkOutput("rst_hitcnt", 32'(HIT_CNT), 32'd0);
      RESET = 1'b0;
      tick(2);

      // Single hit, token high for 5 cycles
      chipWords.push_back(27'h5A5A5A5);
      applyStimulus(1'b1, 1'b1, 1'b0);
      t = cyc;
      tick(5);
      TOKEN = 1'b0;
      waitRead(1, "single");
      r = readCyc[0];
      waitIdle("single");
      tick(2);
      checkOutput("single_freeze_rise", 32'(freezeRise[0]), 32'(t + 3));
      checkOutput("single_read_cycle", 32'(r), 32'(t + 3 + SETUP + 1));
      checkOutput("single_read_count", 32'(readCyc.size()), 32'd1);
      checkOutput("single_write_cycle", 32'(wrCyc[0]), 32'(r + 29));
`ifdef TJMONO_RX_GRAY_EN
      checkOutput("single_data", wrData[0], 32'h46C6A5A5);
`else
      checkOutput("single_data", wrData[0], 32'h45A5A5A5);
`endif
      checkOutput("single_freeze_fall", 32'(freezeFall[0]), 32'(r + 30));
      checkOutput("single_hitcnt", 32'(HIT_CNT), 32'd1);

      // Reset in cycle r+10 of a frame (mid-SHIFT)
      rBase = readCyc.size();
      wBase = wrCyc.size();
      chipWords.push_back(27'h7FFFFFF);
      applyStimulus(1'b1, 1'b1, 1'b0);
      waitRead(rBase + 1, "rstshift");
      TOKEN = 1'b0;
      r = readCyc[rBase];
      waitUntil(r + 10);
      RESET = 1'b1;
      tick(1);
      checkOutput("rstshift_freeze", 32'(FREEZE), 32'd0);
      checkOutput("rstshift_read", 32'(READ), 32'd0);
      checkOutput("rstshift_busy", 32'(BUSY), 32'd0);
      checkOutput("rstshift_write", 32'(FIFO_WRITE), 32'd0);
      checkOutput("rstshift_hitcnt", 32'(HIT_CNT), 32'd0);
      RESET = 1'b0;
      tick(35);
      checkOutput("rstshift_no_write", 32'(wrCyc.size()), 32'(wBase));

      // Three hits while token stays high
      rBase  = readCyc.size();
      wBase  = wrCyc.size();
      fBase  = freezeRise.size();
      ffBase = freezeFall.size();
      chipWords.push_back(27'h0001234);
      chipWords.push_back(27'h0007ABC);
      chipWords.push_back(27'h0000F0F);
      applyStimulus(1'b1, 1'b1, 1'b0);
      waitRead(rBase + 3, "three");
      TOKEN = 1'b0;
      waitIdle("three");
      tick(2);
      checkOutput("three_read_count", 32'(readCyc.size() - rBase), 32'd3);
      checkOutput("three_gap1", 32'(readCyc[rBase+1] - readCyc[rBase]), 32'd30);
      checkOutput("three_gap2", 32'(readCyc[rBase+2] - readCyc[rBase+1]), 32'd30);
      checkOutput("three_freeze_rises", 32'(freezeRise.size() - fBase), 32'd1);
      checkOutput("three_freeze_falls", 32'(freezeFall.size() - ffBase), 32'd1);
      checkOutput("three_data0", wrData[wBase], 32'h40001234);
      checkOutput("three_data1", wrData[wBase+1], 32'h40007ABC);
      checkOutput("three_data2", wrData[wBase+2], 32'h40000F0F);
      checkOutput("three_hitcnt", 32'(HIT_CNT), 32'd3);

      // FIFO full for 20 cycles at PUSH
      rBase  = readCyc.size();
      wBase  = wrCyc.size();
      ffBase = freezeFall.size();
      chipWords.push_back(27'h0005555);
      applyStimulus(1'b1, 1'b1, 1'b0);
      waitRead(rBase + 1, "full");
      TOKEN = 1'b0;
      r = readCyc[rBase];
      heldData = FIFO_DATA;
      waitUntil(r + 29);
      FIFO_FULL = 1'b1;
      waitUntil(r + 40);
      checkOutput("full_freeze_held", 32'(FREEZE), 32'd1);
      checkOutput("full_no_write", 32'(FIFO_WRITE), 32'd0);
      checkOutput("full_data_ready", FIFO_DATA, 32'h40005555);
      waitUntil(r + 49);
      FIFO_FULL = 1'b0;
      waitIdle("full");
      tick(2);
      checkOutput("full_write_cycle", 32'(wrCyc[wBase]), 32'(r + 49));
      checkOutput("full_data", wrData[wBase], 32'h40005555);
      checkOutput("full_read_count", 32'(readCyc.size() - rBase), 32'd1);
      checkOutput("full_freeze_falls", 32'(freezeFall.size() - ffBase), 32'd1);
      checkOutput("full_hitcnt", 32'(HIT_CNT), 32'd4);
      checkOutput("full_prev_data", heldData, 32'h40000F0F);

      // LE/TE field handling: LE Gray 100000, TE Gray 000011
      wBase = wrCyc.size();
      singleFrame({6'b100000, 6'b000011, 6'h15, 9'h0AB}, "gray", r);
`ifdef TJMONO_RX_GRAY_EN
      checkOutput("gray_data", wrData[wBase], {4'h4, 1'b0, 6'd63, 6'd2, 6'h15, 9'h0AB});
`else
      checkOutput("gray_data", wrData[wBase], {4'h4, 1'b0, 6'd32, 6'd3, 6'h15, 9'h0AB});
`endif
      checkOutput("gray_hitcnt", 32'(HIT_CNT), 32'd5);

      // ENABLE low with token high, then enable
      rBase = readCyc.size();
      fBase = freezeRise.size();
      chipWords.push_back(27'h0000F0F);
      applyStimulus(1'b0, 1'b1, 1'b0);
      tick(12);
      checkOutput("disabled_no_freeze", 32'(freezeRise.size() - fBase), 32'd0);
      checkOutput("disabled_no_read", 32'(readCyc.size() - rBase), 32'd0);
      checkOutput("disabled_busy", 32'(BUSY), 32'd0);
      e = cyc;
      ENABLE = 1'b1;
      tick(3);
      checkOutput("enable_freeze_rise", 32'(freezeRise[fBase]), 32'(e + 1));
      waitRead(rBase + 1, "enable");
      TOKEN = 1'b0;
      waitIdle("enable");
      tick(2);
      checkOutput("enable_hitcnt", 32'(HIT_CNT), 32'd6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
